// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: register-held top of stack over a sync-write/async-read RAM,
// valid/ready op handshake, shift-add multiplier and sticky error flags.
module rpn_stack_calc #(
   parameter int N = 16,
   parameter int M = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [N-1:0] d,
   output logic [N-1:0] top,
   output logic [M-1:0] cnt,
   output logic         busy,
   output logic         err_under,
   output logic         err_over,
   output logic         err_illegal
);

   localparam int SW = $clog2(N);

   localparam logic [3:0] OP_PUSH = 4'd0;
   localparam logic [3:0] OP_NEG  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_MUL  = 4'd4;
   localparam logic [3:0] OP_SWAP = 4'd5;
   localparam logic [3:0] OP_DUP  = 4'd6;
   localparam logic [3:0] OP_DROP = 4'd7;
   localparam logic [3:0] OP_PICK = 4'd8;
   localparam logic [3:0] OP_GT   = 4'd9;
   localparam logic [3:0] OP_EQ   = 4'd10;
   localparam logic [3:0] OP_CLR  = 4'd11;

   logic [N-1:0]  r_mem [0:2**M-1];
   logic [N-1:0]  r_top;
   logic [M-1:0]  r_cnt;
   logic          r_busy;
   logic          r_eu;
   logic          r_eo;
   logic          r_ei;
   logic [N-1:0]  r_ma;
   logic [N-1:0]  r_mb;
   logic [N-1:0]  r_acc;
   logic [SW-1:0] r_step;

   logic [N-1:0]  w_below;
   logic [N-1:0]  w_pick;
   logic [M-1:0]  w_k;
   logic [M-1:0]  w_need;
   logic          w_nf;
   logic          w_illegal;
   logic          w_under;
   logic          w_over;
   logic          w_accept;
   logic          w_ok;
   logic          w_wr_en;
   logic [M-1:0]  w_wr_addr;
   logic [N-1:0]  w_acc_nx;

   assign w_below  = r_mem[r_cnt - 1'b1];
   assign w_k      = r_top[M-1:0];
   assign w_pick   = r_mem[r_cnt - w_k];
   assign w_accept = in_valid && !r_busy;
   assign w_acc_nx = r_acc + (r_mb[0] ? r_ma : '0);

   always_comb begin
      w_need    = '0;
      w_nf      = 1'b0;
      w_illegal = 1'b0;
      case (op)
         OP_PUSH:                              w_nf = 1'b1;
         OP_NEG, OP_DROP, OP_PICK, OP_GT:      w_need = M'(1);
         OP_DUP: begin
            w_need = M'(1);
            w_nf   = 1'b1;
         end
         OP_ADD, OP_SUB, OP_MUL, OP_SWAP, OP_EQ: w_need = M'(2);
         OP_CLR:                               ;
         default:                              w_illegal = 1'b1;
      endcase
   end

   // PICK depth out of range counts as underflow, alongside the plain count check.
   assign w_under = (r_cnt < w_need) ||
                    ((op == OP_PICK) && ((w_k == '0) || (w_k > r_cnt - 1'b1)));
   assign w_over  = w_nf && (&r_cnt) && !w_under;
   assign w_ok    = w_accept && !w_illegal && !w_under && !w_over;

   assign w_wr_en   = w_ok && !rst && ((op == OP_PUSH) || (op == OP_DUP) || (op == OP_SWAP));
   assign w_wr_addr = (op == OP_SWAP) ? r_cnt - 1'b1 : r_cnt;

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_addr] <= r_top;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_top  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_eu   <= 1'b0;
         r_eo   <= 1'b0;
         r_ei   <= 1'b0;
         r_ma   <= '0;
         r_mb   <= '0;
         r_acc  <= '0;
         r_step <= '0;
      end else if (r_busy) begin
         r_acc  <= w_acc_nx;
         r_ma   <= r_ma << 1;
         r_mb   <= r_mb >> 1;
         r_step <= r_step + 1'b1;
         if (r_step == SW'(N-1)) begin
            r_top  <= w_acc_nx;
            r_cnt  <= r_cnt - 1'b1;
            r_busy <= 1'b0;
         end
      end else if (w_accept) begin
         if (w_illegal)    r_ei <= 1'b1;
         else if (w_under) r_eu <= 1'b1;
         else if (w_over)  r_eo <= 1'b1;
         else begin
            case (op)
               OP_PUSH: begin
                  r_top <= d;
                  r_cnt <= r_cnt + 1'b1;
               end
               OP_NEG:  r_top <= -r_top;
               OP_ADD: begin
                  r_top <= w_below + r_top;
                  r_cnt <= r_cnt - 1'b1;
               end
               OP_SUB: begin
                  r_top <= w_below - r_top;
                  r_cnt <= r_cnt - 1'b1;
               end
               OP_MUL: begin
                  r_ma   <= w_below;
                  r_mb   <= r_top;
                  r_acc  <= '0;
                  r_step <= '0;
                  r_busy <= 1'b1;
               end
               OP_SWAP: r_top <= w_below;
               OP_DUP:  r_cnt <= r_cnt + 1'b1;
               OP_DROP: begin
                  r_top <= (r_cnt == M'(1)) ? '0 : w_below;
                  r_cnt <= r_cnt - 1'b1;
               end
               OP_PICK: r_top <= w_pick;
               OP_GT:   r_top <= (!r_top[N-1] && (r_top != '0)) ? N'(1) : '0;
               OP_EQ: begin
                  r_top <= (w_below == r_top) ? N'(1) : '0;
                  r_cnt <= r_cnt - 1'b1;
               end
               OP_CLR: begin
                  r_top <= '0;
                  r_cnt <= '0;
                  r_eu  <= 1'b0;
                  r_eo  <= 1'b0;
                  r_ei  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready    = !r_busy;
   assign top         = r_top;
   assign cnt         = r_cnt;
   assign busy        = r_busy;
   assign err_under   = r_eu;
   assign err_over    = r_eo;
   assign err_illegal = r_ei;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: two instances (M=10 and M=2) checked every cycle
// against an array-based stack model, plus hand-computed directed expectations.
module tb_rpn_stack_calc;

   localparam int N  = 16;
   localparam int MA = 10;
   localparam int MB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst   [2];
   logic          v     [2];
   logic [3:0]    op    [2];
   logic [N-1:0]  dv    [2];
   logic          rdy   [2];
   logic [N-1:0]  top   [2];
   logic          busy  [2];
   logic          eu    [2];
   logic          eo    [2];
   logic          ei    [2];
   logic [MA-1:0] cnt_a;
   logic [MB-1:0] cnt_b;

   rpn_stack_calc #(.N(N), .M(MA)) u_a (
      .clk(clk), .rst(rst[0]), .in_valid(v[0]), .in_ready(rdy[0]), .op(op[0]), .d(dv[0]),
      .top(top[0]), .cnt(cnt_a), .busy(busy[0]), .err_under(eu[0]), .err_over(eo[0]),
      .err_illegal(ei[0]));

   rpn_stack_calc #(.N(N), .M(MB)) u_b (
      .clk(clk), .rst(rst[1]), .in_valid(v[1]), .in_ready(rdy[1]), .op(op[1]), .d(dv[1]),
      .top(top[1]), .cnt(cnt_b), .busy(busy[1]), .err_under(eu[1]), .err_over(eo[1]),
      .err_illegal(ei[1]));

   // Behavioural model: stk[k][0..sz-1] holds the stack, last entry is the top.
   logic [N-1:0] stk [2][1024];
   int           sz   [2];
   bit           mu   [2];
   bit           mo   [2];
   bit           mi   [2];
   int           bl   [2];
   logic [N-1:0] pend [2];
   bit           acc  [2];
   int           cap  [2];

   int  nchk = 0;
   int  nerr = 0;
   bit  chk_en = 1'b0;

   function automatic logic [N-1:0] mtop(input int k);
      return (sz[k] > 0) ? stk[k][sz[k]-1] : '0;
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
      end
   endtask

   task automatic mstep(input int k);
      logic [N-1:0] t, b;
      int n, need, kk;
      bit nf, und;
      acc[k] = 1'b0;
      if (rst[k]) begin
         sz[k] = 0; mu[k] = 0; mo[k] = 0; mi[k] = 0; bl[k] = 0;
      end else if (bl[k] > 0) begin
         bl[k]--;
         if (bl[k] == 0) begin
            sz[k]--;
            stk[k][sz[k]-1] = pend[k];
         end
      end else if (v[k]) begin
         acc[k] = 1'b1;
         n = sz[k];
         t = mtop(k);
         b = (n >= 2) ? stk[k][n-2] : '0;
         need = 0;
         nf = 1'b0;
         case (op[k])
            4'd0: nf = 1'b1;
            4'd1, 4'd7, 4'd8, 4'd9: need = 1;
            4'd6: begin need = 1; nf = 1'b1; end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd10: need = 2;
            default: ;
         endcase
         kk  = int'(t) & cap[k];
         und = (n < need) || (op[k] == 4'd8 && (kk < 1 || kk > n - 1));
         if (op[k] >= 4'd12) mi[k] = 1'b1;
         else if (und) mu[k] = 1'b1;
         else if (nf && n == cap[k]) mo[k] = 1'b1;
         else begin
            case (op[k])
               4'd0: begin stk[k][n] = dv[k]; sz[k] = n + 1; end
               4'd1: stk[k][n-1] = -t;
               4'd2: begin stk[k][n-2] = b + t; sz[k] = n - 1; end
               4'd3: begin stk[k][n-2] = b - t; sz[k] = n - 1; end
               4'd4: begin pend[k] = b * t; bl[k] = N; end
               4'd5: begin stk[k][n-1] = b; stk[k][n-2] = t; end
               4'd6: begin stk[k][n] = t; sz[k] = n + 1; end
               4'd7: sz[k] = n - 1;
               4'd8: stk[k][n-1] = stk[k][n-1-kk];
               4'd9: stk[k][n-1] = ($signed(t) > 16'sd0) ? 16'd1 : 16'd0;
               4'd10: begin stk[k][n-2] = (b == t) ? 16'd1 : 16'd0; sz[k] = n - 1; end
               4'd11: begin sz[k] = 0; mu[k] = 0; mo[k] = 0; mi[k] = 0; end
               default: ;
            endcase
         end
      end
   endtask

   always @(posedge clk) begin
      mstep(0);
      mstep(1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("top", k, int'(top[k]), int'(mtop(k)));
            chk("cnt", k, (k == 0) ? int'(cnt_a) : int'(cnt_b), sz[k]);
            chk("busy", k, int'(busy[k]), int'(bl[k] > 0));
            chk("in_ready", k, int'(rdy[k]), int'(bl[k] == 0));
            chk("err_under", k, int'(eu[k]), int'(mu[k]));
            chk("err_over", k, int'(eo[k]), int'(mo[k]));
            chk("err_illegal", k, int'(ei[k]), int'(mi[k]));
         end
      end
   end

   task automatic send(input int k, input logic [3:0] o, input logic [N-1:0] val);
      bit got;
      got = 1'b0;
      v[k] = 1'b1; op[k] = o; dv[k] = val;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk); #1;
         got = acc[k];
      end
      if (!got) begin
         nerr++;
         $display("FAIL accept dut%0d op %0d: got no acceptance expected acceptance", k, o);
      end
      v[k] = 1'b0;
   endtask

   task automatic do_reset(input int k);
      rst[k] = 1'b1;
      @(posedge clk); #1;
      rst[k] = 1'b0;
   endtask

   int nb;

   initial begin
      cap[0] = 2**MA - 1;
      cap[1] = 2**MB - 1;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; v[k] = 1'b0; op[k] = '0; dv[k] = '0;
         sz[k] = 0; bl[k] = 0; mu[k] = 0; mo[k] = 0; mi[k] = 0; acc[k] = 0; pend[k] = '0;
      end
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk_en = 1'b1;
      chk("reset top", 0, int'(top[0]), 0);
      chk("reset cnt", 0, int'(cnt_a), 0);

      // 5 7 SUB -> -2
      send(0, 4'd0, 16'd5); send(0, 4'd0, 16'd7); send(0, 4'd3, 16'd0);
      chk("sub top", 0, int'(top[0]), 16'hFFFE);
      chk("sub cnt", 0, int'(cnt_a), 1);
      chk("sub flags", 0, int'({eu[0], eo[0], ei[0]}), 0);

      // 3 -4 MUL with a PUSH 1 queued behind it
      do_reset(0);
      send(0, 4'd0, 16'd3); send(0, 4'd0, 16'hFFFC); send(0, 4'd4, 16'd0);
      v[0] = 1'b1; op[0] = 4'd0; dv[0] = 16'd1;
      nb = 0;
      while (busy[0] && nb < 40) begin
         chk("mul in_ready", 0, int'(rdy[0]), 0);
         nb++;
         @(posedge clk); #1;
      end
      chk("mul busy cycles", 0, nb, 16);
      chk("mul top", 0, int'(top[0]), 16'hFFF4);
      chk("mul cnt", 0, int'(cnt_a), 1);
      @(posedge clk); #1;
      v[0] = 1'b0;
      chk("queued push top", 0, int'(top[0]), 1);
      chk("queued push cnt", 0, int'(cnt_a), 2);

      // empty-stack ADD, illegal opcode, then CLR
      do_reset(0);
      send(0, 4'd2, 16'd0); send(0, 4'd13, 16'd0);
      chk("empty err_under", 0, int'(eu[0]), 1);
      chk("empty err_illegal", 0, int'(ei[0]), 1);
      chk("empty top", 0, int'(top[0]), 0);
      chk("empty cnt", 0, int'(cnt_a), 0);
      send(0, 4'd11, 16'd0);
      chk("clr flags", 0, int'({eu[0], eo[0], ei[0]}), 0);

      // small instance overflow
      do_reset(1);
      for (int i = 1; i <= 4; i++) send(1, 4'd0, 16'(i));
      chk("full cnt", 1, int'(cnt_b), 3);
      chk("full top", 1, int'(top[1]), 3);
      chk("full err_over", 1, int'(eo[1]), 1);
      send(1, 4'd6, 16'd0);
      chk("full dup cnt", 1, int'(cnt_b), 3);
      chk("full dup top", 1, int'(top[1]), 3);

      // PICK in range and out of range
      do_reset(0);
      send(0, 4'd0, 16'd10); send(0, 4'd0, 16'd20); send(0, 4'd0, 16'd30);
      send(0, 4'd0, 16'd2); send(0, 4'd8, 16'd0);
      chk("pick top", 0, int'(top[0]), 20);
      chk("pick cnt", 0, int'(cnt_a), 4);
      send(0, 4'd0, 16'd9); send(0, 4'd8, 16'd0);
      chk("pick bad err_under", 0, int'(eu[0]), 1);
      chk("pick bad top", 0, int'(top[0]), 9);
      chk("pick bad cnt", 0, int'(cnt_a), 5);

      // reset during the 5th busy cycle of a MUL
      do_reset(0);
      send(0, 4'd0, 16'd3); send(0, 4'd0, 16'd4); send(0, 4'd4, 16'd0);
      repeat (4) begin @(posedge clk); #1; end
      chk("mul mid busy", 0, int'(busy[0]), 1);
      do_reset(0);
      chk("abort cnt", 0, int'(cnt_a), 0);
      chk("abort top", 0, int'(top[0]), 0);
      chk("abort busy", 0, int'(busy[0]), 0);
      chk("abort in_ready", 0, int'(rdy[0]), 1);

      // randomized traffic on both instances
      repeat (3000) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            int r;
            rst[k] = ($urandom_range(0, 299) == 0);
            v[k]   = ($urandom_range(0, 9) < 7);
            r      = $urandom_range(0, 99);
            if (r < 30)      op[k] = 4'd0;
            else if (r < 33) op[k] = 4'($urandom_range(12, 15));
            else if (r < 36) op[k] = 4'd11;
            else             op[k] = 4'($urandom_range(1, 10));
            dv[k] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 6)) : 16'($urandom);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin rst[k] = 1'b0; v[k] = 1'b0; end
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
